// File: rtl/pwm_from_count_if.sv
// Duty-cycle load channel for pwm_from_count.
// The producer (master) offers duty_in with duty_valid and holds it until the
// block (slave) raises duty_ready; a transfer happens when both are high.
interface pwm_from_count_if #(
   parameter int CNT_W = 4
);
   logic             duty_valid;
   logic             duty_ready;
   logic [CNT_W:0]   duty_in;

   modport master (
      output duty_valid,
      output duty_in,
      input  duty_ready
   );

   modport slave (
      input  duty_valid,
      input  duty_in,
      output duty_ready
   );
endinterface

// File: rtl/pwm_from_count.sv
// PWM generator driven by an external free-running up counter.
// Watches the sampled count for max->0 wraps, swaps in a shadowed duty value
// only on a wrap so that no period is ever cut short, and counts wraps while
// running.
// Optional feature: define CNT_SEQ_CHECK_EN to add a sticky count-sequence
// checker on cnt_err; without it cnt_err is tied low.
module pwm_from_count #(
   parameter int CNT_W   = 4,
   parameter int EPOCH_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [CNT_W-1:0]   cnt_in,
   pwm_from_count_if.slave    duty,
   output logic               pwm_out,
   output logic               wrap_pulse,
   output logic [EPOCH_W-1:0] epoch_cnt,
   output logic               cnt_err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W:0]   DUTY_MAX = {1'b1, {CNT_W{1'b0}}};

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W:0]     pend_duty_q;
   logic [CNT_W:0]     pend_duty_d;
   logic               pend_flag_q;
   logic               pend_flag_d;
   logic [CNT_W:0]     act_duty_q;
   logic [CNT_W:0]     act_duty_d;
   logic               pwm_d;
   logic [EPOCH_W-1:0] epoch_d;

   logic               wrap;
   logic               accept;
   logic [CNT_W:0]     duty_sat;

   // A wrap is only a genuine max->0 step; an upstream counter reset that
   // jumps to 0 from anywhere else does not count.
   assign wrap     = (cnt_q == CNT_MAX) && (cnt_in == '0);
   assign accept   = duty.duty_valid && !pend_flag_q;
   assign duty_sat = (duty.duty_in > DUTY_MAX) ? DUTY_MAX : duty.duty_in;

   // Only one duty value can be shadowed at a time.
   assign duty.duty_ready = !pend_flag_q;

   // Next-state logic: apply the shadowed duty on a wrap, capture newly
   // offered duty, and compute the PWM level from the duty that governs
   // the current count (including one just swapped in at this wrap).
   always_comb begin
      state_d     = state_q;
      pend_duty_d = pend_duty_q;
      pend_flag_d = pend_flag_q;
      act_duty_d  = act_duty_q;
      pwm_d       = 1'b0;
      epoch_d     = epoch_cnt;

      if (wrap && pend_flag_q) begin
         act_duty_d  = pend_duty_q;
         pend_flag_d = 1'b0;
         state_d     = RUN;
      end

      if (accept) begin
         pend_duty_d = duty_sat;
         pend_flag_d = 1'b1;
      end

      if (state_d == RUN) begin
         pwm_d = ({1'b0, cnt_in} < act_duty_d);
         if (wrap) begin
            epoch_d = epoch_cnt + EPOCH_W'(1);
         end
      end
   end

   // State and output registers; reset discards both pending and active duty.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         pend_duty_q <= '0;
         pend_flag_q <= 1'b0;
         act_duty_q  <= '0;
         pwm_out     <= 1'b0;
         wrap_pulse  <= 1'b0;
         epoch_cnt   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_in;
         pend_duty_q <= pend_duty_d;
         pend_flag_q <= pend_flag_d;
         act_duty_q  <= act_duty_d;
         pwm_out     <= pwm_d;
         wrap_pulse  <= wrap;
         epoch_cnt   <= epoch_d;
      end
   end

`ifdef CNT_SEQ_CHECK_EN
   logic             seen_q;
   logic [CNT_W-1:0] cnt_inc;

   assign cnt_inc = cnt_q + CNT_W'(1);

   // Sticky sequence checker; the first cycle after reset is skipped because
   // cnt_q does not yet hold a real sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         seen_q  <= 1'b0;
         cnt_err <= 1'b0;
      end else begin
         seen_q <= 1'b1;
         if (seen_q && (cnt_in != cnt_inc) && (cnt_in != '0)) begin
            cnt_err <= 1'b1;
         end
      end
   end
`else
   assign cnt_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_from_count.sv
// Self-checking bench for pwm_from_count: walks the counter through whole
// periods, loads duty values through the handshake, and scores pwm_out,
// wrap_pulse, epoch_cnt and cnt_err one cycle after each count is driven.
module tb_pwm_from_count;

   logic       clk;
   logic       rst;
   logic [3:0] cnt_in;
   logic       pwm_out;
   logic       wrap_pulse;
   logic [7:0] epoch_cnt;
   logic       cnt_err;

   pwm_from_count_if #(.CNT_W(4)) duty_if ();

   pwm_from_count #(
      .CNT_W   (4),
      .EPOCH_W (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt_in     (cnt_in),
      .duty       (duty_if),
      .pwm_out    (pwm_out),
      .wrap_pulse (wrap_pulse),
      .epoch_cnt  (epoch_cnt),
      .cnt_err    (cnt_err)
   );

   typedef struct packed {
      logic       pwm;
      logic       wrap;
      logic [7:0] epoch;
      logic       err;
   } exp_t;

   exp_t       exp_q[$];
   int         n_checks;
   int         n_fails;
   logic [3:0] last_cnt;
   logic [7:0] exp_epoch;
   logic       exp_err;

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one count, queue the expected registered response, then pop and
   // score it just after the edge that produces it.
   task automatic apply_stimulus(input logic [3:0] c, input logic [4:0] d, input logic run);
      exp_t e;
      logic w;
      cnt_in = c;
      w = (c == 4'd0) && (last_cnt == 4'd15);
      if (w && run) exp_epoch = exp_epoch + 8'd1;
      e.pwm   = run && ({1'b0, c} < d);
      e.wrap  = w;
      e.epoch = exp_epoch;
      e.err   = exp_err;
      exp_q.push_back(e);
      last_cnt = c;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      n_checks++;
      if (pwm_out !== e.pwm) begin
         n_fails++;
         $display("[TB] FAIL pwm_out cnt=%0d got %b want %b", c, pwm_out, e.pwm);
      end
      n_checks++;
      if (wrap_pulse !== e.wrap) begin
         n_fails++;
         $display("[TB] FAIL wrap_pulse cnt=%0d got %b want %b", c, wrap_pulse, e.wrap);
      end
      n_checks++;
      if (epoch_cnt !== e.epoch) begin
         n_fails++;
         $display("[TB] FAIL epoch_cnt cnt=%0d got %0d want %0d", c, epoch_cnt, e.epoch);
      end
      n_checks++;
      if (cnt_err !== e.err) begin
         n_fails++;
         $display("[TB] FAIL cnt_err cnt=%0d got %b want %b", c, cnt_err, e.err);
      end
   endtask

   // Walk counts lo..hi at expected duty d, optionally offering a new duty
   // for exactly one cycle at count offer_at.
   task automatic run_range(input int lo, input int hi, input logic [4:0] d, input logic run,
                            input int offer_at, input logic [4:0] offer_val);
      for (int c = lo; c <= hi; c++) begin
         if (c == offer_at) begin
            duty_if.duty_valid = 1'b1;
            duty_if.duty_in    = offer_val;
            n_checks++;
            if (duty_if.duty_ready !== 1'b1) begin
               n_fails++;
               $display("[TB] FAIL ready_before_offer cnt=%0d got %b want 1", c, duty_if.duty_ready);
            end
         end
         apply_stimulus(4'(c), d, run);
         if (c == offer_at) begin
            duty_if.duty_valid = 1'b0;
            n_checks++;
            if (duty_if.duty_ready !== 1'b0) begin
               n_fails++;
               $display("[TB] FAIL ready_after_accept cnt=%0d got %b want 0", c, duty_if.duty_ready);
            end
         end
      end
   endtask

   // Hold reset with the counter parked at c, check every output, release.
   task automatic do_reset(input logic [3:0] c, input int cycles);
      rst                = 1'b1;
      cnt_in             = c;
      duty_if.duty_valid = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      n_checks++;
      if (pwm_out !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_pwm got %b want 0", pwm_out); end
      n_checks++;
      if (wrap_pulse !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_wrap got %b want 0", wrap_pulse); end
      n_checks++;
      if (epoch_cnt !== 8'd0) begin n_fails++; $display("[TB] FAIL reset_epoch got %0d want 0", epoch_cnt); end
      n_checks++;
      if (cnt_err !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_err got %b want 0", cnt_err); end
      n_checks++;
      if (duty_if.duty_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_ready got %b want 1", duty_if.duty_ready); end
      rst       = 1'b0;
      last_cnt  = 4'd0;
      exp_epoch = 8'd0;
      exp_err   = 1'b0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      do_reset(4'd0, 3);
   endtask

   // No duty offered: output stays low, epoch stays 0, wraps still pulse.
   task automatic test_idle_free_run();
      $display("[TB] test_idle_free_run");
      run_range(0, 15, 5'd0, 1'b0, -1, 5'd0);
      run_range(0, 15, 5'd0, 1'b0, -1, 5'd0);
   endtask

   task automatic test_duty_accept();
      $display("[TB] test_duty_accept");
      run_range(0, 15, 5'd0, 1'b0, 7, 5'd5);
      n_checks++;
      if (duty_if.duty_ready !== 1'b0) begin
         n_fails++;
         $display("[TB] FAIL ready_held_low got %b want 0", duty_if.duty_ready);
      end
      run_range(0, 15, 5'd5, 1'b1, -1, 5'd0);
      n_checks++;
      if (duty_if.duty_ready !== 1'b1) begin
         n_fails++;
         $display("[TB] FAIL ready_after_apply got %b want 1", duty_if.duty_ready);
      end
   endtask

   // Duty 0, 16, then 20 (saturates to 16), each taking effect at a wrap.
   task automatic test_duty_extremes();
      $display("[TB] test_duty_extremes");
      run_range(0, 15, 5'd5,  1'b1, 3,  5'd0);
      run_range(0, 15, 5'd0,  1'b1, 10, 5'd16);
      run_range(0, 15, 5'd16, 1'b1, 2,  5'd20);
   endtask

   // Offer arriving on the wrap cycle is deferred to the following wrap.
   task automatic test_back_to_back();
      $display("[TB] test_back_to_back");
      run_range(0, 15, 5'd16, 1'b1, 4,  5'd8);
      run_range(0, 15, 5'd8,  1'b1, -1, 5'd0);
      run_range(0, 15, 5'd8,  1'b1, 0,  5'd3);
      run_range(0, 15, 5'd3,  1'b1, -1, 5'd0);
   endtask

   // Reset with a pending duty: nothing is applied afterwards, block idles.
   task automatic test_reset_mid();
      $display("[TB] test_reset_mid");
      run_range(0, 9, 5'd3, 1'b1, 5, 5'd7);
      do_reset(4'd10, 1);
      run_range(11, 15, 5'd0, 1'b0, -1, 5'd0);
      run_range(0, 15, 5'd0, 1'b0, -1, 5'd0);
   endtask

   // Count skip 3->5 flags cnt_err when the checker is built; 6->0 never does.
   task automatic test_seq_check();
      $display("[TB] test_seq_check");
      run_range(0, 3, 5'd0, 1'b0, -1, 5'd0);
`ifdef CNT_SEQ_CHECK_EN
      exp_err = 1'b1;
`endif
      apply_stimulus(4'd5, 5'd0, 1'b0);
      apply_stimulus(4'd6, 5'd0, 1'b0);
      apply_stimulus(4'd7, 5'd0, 1'b0);
      do_reset(4'd8, 1);
      apply_stimulus(4'd4, 5'd0, 1'b0);
      apply_stimulus(4'd5, 5'd0, 1'b0);
      apply_stimulus(4'd6, 5'd0, 1'b0);
      apply_stimulus(4'd0, 5'd0, 1'b0);
      apply_stimulus(4'd1, 5'd0, 1'b0);
   endtask

   // Main sequence
   initial begin
      n_checks           = 0;
      n_fails            = 0;
      last_cnt           = 4'd0;
      exp_epoch          = 8'd0;
      exp_err            = 1'b0;
      rst                = 1'b1;
      cnt_in             = 4'd0;
      duty_if.duty_valid = 1'b0;
      duty_if.duty_in    = 5'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_idle_free_run();
      test_duty_accept();
      test_duty_extremes();
      test_back_to_back();
      test_reset_mid();
      test_seq_check();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Guard against a stalled run
   initial begin
      #500000;
      $display("[TB] FAIL timeout got running want finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/pwm_from_count.md
# pwm_from_count

Downstream consumer of the 4-bit free-running up counter. Samples the counter value every cycle, detects wrap-around (max→0), and produces a registered PWM waveform whose duty is loaded through a valid/ready handshake. New duty values are shadowed and applied only at a wrap boundary, so no period is ever truncated. The block also maintains an epoch (wrap) counter and, optionally, a count-sequence checker.

## Interface
- CNT_W, 4, width of the sampled counter value; period = 2^CNT_W cycles
- EPOCH_W, 8, width of the wrap/epoch counter
- clk  input  1  rising-edge clock, same clock as the counter
- rst  input  1  reset: synchronous, active-high; one clock, synchronous active-high reset
- cnt_in  input  CNT_W  counter value from upstream counter
- duty_valid  input  1  duty_in is offered
- duty_ready  output  1  block can accept a duty value
- duty_in  input  CNT_W+1  high cycles per period, 0..2^CNT_W; larger values saturate to 2^CNT_W
- pwm_out  output  1  registered PWM output
- wrap_pulse  output  1  one-cycle pulse per detected wrap
- epoch_cnt  output  EPOCH_W  number of wraps seen in RUN, modulo 2^EPOCH_W
- cnt_err  output  1  sticky sequence error (see Configuration)

## Operation
- Internal regs: cnt_q (previous cnt_in), pend_duty, pend_flag, act_duty, state ∈ {IDLE, RUN}.
- wrap = (cnt_q == 2^CNT_W−1) && (cnt_in == 0), evaluated combinationally each cycle.
- Handshake: duty_ready = !pend_flag. Accept when duty_valid && duty_ready: pend_duty ← sat(duty_in), pend_flag ← 1. Holding duty_valid with ready low has no effect; producer holds data until accepted.
- On wrap with pend_flag=1: act_duty ← pend_duty, pend_flag ← 0, state ← RUN. The new duty governs the cycle with cnt_in==0 (the new period) onward.
- On wrap with pend_flag=0: act_duty unchanged.
- Accept and wrap in the same cycle with pend_flag=0: value is accepted into pend_duty, applied at the following wrap, not this one.
- IDLE: pwm_out ← 0; epoch_cnt held at 0; leaves IDLE only on a wrap with a pending duty.
- RUN: pwm_out ← (cnt_in < eff_duty), eff_duty = value act_duty holds after this cycle's update. Duty 0 → constantly low; duty 2^CNT_W → constantly high.
- wrap_pulse ← wrap (in any state). epoch_cnt ← epoch_cnt+1 on each wrap while in RUN or entering RUN, wraps modulo 2^EPOCH_W.
- cnt_q ← cnt_in every cycle.

## Timing
- All outputs except duty_ready are registered; 1-cycle latency from cnt_in to pwm_out/wrap_pulse.
- duty_ready is combinational from pend_flag; it is low from the cycle after acceptance until the cycle after the applying wrap.
- Reset values: pwm_out=0, wrap_pulse=0, epoch_cnt=0, cnt_err=0, duty_ready=1; cnt_q=0, pend_flag=0, act_duty=0, state=IDLE.
- Reset mid-operation discards pending and active duty; the first cnt_in==0 after reset is not a wrap, because cnt_q=0.
- Upstream counter reset (cnt_in jumping to 0 from a non-max value) is not a wrap; the duty is not swapped.

## Configuration
- CNT_SEQ_CHECK_EN defined: each cycle after the first post-reset cycle, cnt_err is set and held until rst if cnt_in ≠ (cnt_q+1) mod 2^CNT_W and cnt_in ≠ 0.
- Not defined: checker logic is absent and cnt_err is tied to 0.

## Test plan
- Reset, counter free-running, no duty offered → pwm_out=0 and epoch_cnt=0 throughout; wrap_pulse fires once per 16 cycles.
- Offer duty 5 mid-period → accepted in one cycle, duty_ready low until the wrap. After the wrap, pwm_out is high for counts 0–4 (5 cycles) and low for 11 cycles, delayed by 1 cycle; epoch_cnt=1.
- Duty 0, then duty 16, then duty 20 → constant low, constant high, and constant high (saturated) respectively, each switching exactly at a wrap boundary.
- Offer duty 3 in the same cycle as a wrap while running at duty 8 → period N stays 8-high; period N+1 is 3-high.
- Assert rst while counter is at 9 with pending duty 7 → all outputs reset; no duty is applied at the next 15→0 transition; block stays in IDLE.
- With CNT_SEQ_CHECK_EN, drive cnt_in 3→5 → cnt_err=1 the next cycle and held until rst. Drive cnt_in 6→0 → no error and no wrap_pulse.
